// File: rtl/aemb2_xsl_fifo.sv
// XSL (FSL-style) Wishbone responder: per-channel TX/RX FIFOs with blocking put/get.
// Optional AEMB_XSL_TIMEOUT_EN: force-ack a blocked transfer after AEMB_XTO cycles and flag xsl_err_o.

module aemb2_xsl_fifo_q #(
  parameter int AW = 2,
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd    = pop & ~empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign wr    = push & (~full | rd);
  assign head  = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdat;
        wp      <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module aemb2_xsl_fifo #(
  parameter int AEMB_XWB = 3,
  parameter int AEMB_XFD = 2,
  parameter int AEMB_XTO = 255,
  localparam int CW  = AEMB_XWB - 2,
  localparam int NCH = 2 ** CW
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              xwb_cyc_i,
  input  logic              xwb_stb_i,
  input  logic              xwb_wre_i,
  input  logic [CW-1:0]     xwb_adr_i,
  input  logic [3:0]        xwb_sel_i,
  input  logic [31:0]       xwb_dat_i,
  input  logic              xwb_tag_i,
  output logic              xwb_ack_o,
  output logic [31:0]       xwb_dat_o,
  output logic              xwb_tag_o,
  output logic [NCH*32-1:0] xsl_txd_o,
  output logic [NCH-1:0]    xsl_txt_o,
  output logic [NCH-1:0]    xsl_txv_o,
  input  logic [NCH-1:0]    xsl_txr_i,
  input  logic [NCH*32-1:0] xsl_rxd_i,
  input  logic [NCH-1:0]    xsl_rxt_i,
  input  logic [NCH-1:0]    xsl_rxv_i,
  output logic [NCH-1:0]    xsl_rxr_o,
  output logic [NCH-1:0]    xsl_err_o
);
  typedef enum logic {S_IDLE, S_ACK} st_t;

  st_t                  st;
  logic [NCH-1:0]       tx_full, tx_empty, rx_full, rx_empty, tx_push, rx_pop;
  logic [NCH-1:0][32:0] tx_head, rx_head;
  logic                 req, rdy, go;
  logic                 sel_unused;

  assign sel_unused = ^{xwb_sel_i, 8'(AEMB_XTO)};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    aemb2_xsl_fifo_q #(.AW(AEMB_XFD), .DW(33)) u_tx (
      .clk(sys_clk_i), .rst_n(sys_rst_i),
      .push(tx_push[g]), .pop(xsl_txr_i[g]), .wdat({xwb_tag_i, xwb_dat_i}),
      .head(tx_head[g]), .full(tx_full[g]), .empty(tx_empty[g])
    );
    aemb2_xsl_fifo_q #(.AW(AEMB_XFD), .DW(33)) u_rx (
      .clk(sys_clk_i), .rst_n(sys_rst_i),
      .push(xsl_rxv_i[g]), .pop(rx_pop[g]), .wdat({xsl_rxt_i[g], xsl_rxd_i[32*g +: 32]}),
      .head(rx_head[g]), .full(rx_full[g]), .empty(rx_empty[g])
    );
    assign xsl_txd_o[32*g +: 32] = tx_head[g][31:0];
    assign xsl_txt_o[g]          = tx_head[g][32];
    assign xsl_txv_o[g]          = ~tx_empty[g];
    assign xsl_rxr_o[g]          = ~rx_full[g];
  end

  assign req = xwb_cyc_i & xwb_stb_i;
  assign rdy = xwb_wre_i ? ~tx_full[xwb_adr_i] : ~rx_empty[xwb_adr_i];
  assign go  = (st == S_IDLE) & req & rdy;

  always_comb begin
    tx_push = '0;
    rx_pop  = '0;
    if (go) begin
      if (xwb_wre_i) tx_push[xwb_adr_i] = 1'b1;
      else           rx_pop[xwb_adr_i]  = 1'b1;
    end
  end

`ifdef AEMB_XSL_TIMEOUT_EN
  localparam logic [7:0] XTO_M1 = 8'(AEMB_XTO - 1);
  logic [7:0] blk;
  logic       force_ack;

  // Fires on the blocked cycle in which the counter would reach AEMB_XTO.
  assign force_ack = (st == S_IDLE) & req & ~rdy & (blk == XTO_M1);

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i)                                      blk <= '0;
    else if ((st == S_IDLE) & req & ~rdy & ~force_ack)   blk <= blk + 1'b1;
    else                                                 blk <= '0;
  end
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      st        <= S_IDLE;
      xwb_ack_o <= 1'b0;
      xwb_dat_o <= '0;
      xwb_tag_o <= 1'b0;
`ifdef AEMB_XSL_TIMEOUT_EN
      xsl_err_o <= '0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (go) begin
            st        <= S_ACK;
            xwb_ack_o <= 1'b1;
            if (!xwb_wre_i) {xwb_tag_o, xwb_dat_o} <= rx_head[xwb_adr_i];
          end
`ifdef AEMB_XSL_TIMEOUT_EN
          else if (force_ack) begin
            st                   <= S_ACK;
            xwb_ack_o            <= 1'b1;
            xsl_err_o[xwb_adr_i] <= 1'b1;
            if (!xwb_wre_i) {xwb_tag_o, xwb_dat_o} <= '0;
          end
`endif
        end
        default: begin
          st        <= S_IDLE;
          xwb_ack_o <= 1'b0;
        end
      endcase
    end
  end

`ifndef AEMB_XSL_TIMEOUT_EN
  assign xsl_err_o = '0;
`endif
endmodule

// File: tb/tb_aemb2_xsl_fifo.sv
// Directed bench for aemb2_xsl_fifo: put/get blocking, FIFO full/empty, reset mid-block, optional timeout.
module tb_aemb2_xsl_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, wre, tag_i;
  logic [0:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack, tag_o;
  logic [31:0] dat_o;
  logic [63:0] txd, rxd;
  logic [1:0]  txt, txv, txr, rxt, rxv, rxr, err;

  int n_chk = 0;
  int n_fail = 0;

  aemb2_xsl_fifo #(.AEMB_XWB(3), .AEMB_XFD(2), .AEMB_XTO(8)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n),
    .xwb_cyc_i(cyc), .xwb_stb_i(stb), .xwb_wre_i(wre), .xwb_adr_i(adr),
    .xwb_sel_i(sel), .xwb_dat_i(dat_i), .xwb_tag_i(tag_i),
    .xwb_ack_o(ack), .xwb_dat_o(dat_o), .xwb_tag_o(tag_o),
    .xsl_txd_o(txd), .xsl_txt_o(txt), .xsl_txv_o(txv), .xsl_txr_i(txr),
    .xsl_rxd_i(rxd), .xsl_rxt_i(rxt), .xsl_rxv_i(rxv), .xsl_rxr_o(rxr),
    .xsl_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Bus transfer; returns the number of edges until ack (20 = never acked).
  task automatic xfer(input logic w, input int ch, input logic [31:0] d, input logic t,
                      output int n, output logic [31:0] rd, output logic rt);
    cyc = 1'b1; stb = 1'b1; wre = w; adr = 1'(ch); dat_i = d; tag_i = t; n = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    rd = dat_o; rt = tag_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    logic rt;
    rst_n = 1'b0; cyc = 0; stb = 0; wre = 0; adr = 0; sel = 4'hf; dat_i = 0; tag_i = 0;
    txr = 0; rxd = 0; rxt = 0; rxv = 0;
    tick(); tick();
    chk("rst_ack", 64'(ack), 0);
    chk("rst_dat", 64'(dat_o), 0);
    chk("rst_txv", 64'(txv), 0);
    chk("rst_rxr", 64'(rxr), 2'b11);
    chk("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    tick();

    // single put to ch0
    xfer(1'b1, 0, 32'hDEADBEEF, 1'b1, n, rd, rt);
    chk("put0_lat", 64'(n), 1);
    chk("put0_txd", 64'(txd[31:0]), 64'hDEADBEEF);
    chk("put0_txt", 64'(txt[0]), 1);
    chk("put0_txv", 64'(txv[0]), 1);

    // fill ch1 TX
    for (int i = 1; i <= 4; i++) begin
      xfer(1'b1, 1, 32'(i), 1'b0, n, rd, rt);
      chk("fill_ack", 64'(n < 20), 1);
    end
    chk("fill_txv", 64'(txv[1]), 1);
    chk("fill_head", 64'(txd[63:32]), 1);
    cyc = 1; stb = 1; wre = 1; adr = 1; dat_i = 5;
    for (int i = 0; i < 3; i++) begin tick(); chk("full_noack", 64'(ack), 0); end
    txr[1] = 1'b1;
    tick();
    txr[1] = 1'b0;
    chk("pop_noack", 64'(ack), 0);
    chk("pop_head", 64'(txd[63:32]), 2);
    tick();
    chk("put5_ack", 64'(ack), 1);
    cyc = 0; stb = 0;
    txr[1] = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      chk("drain", 64'(txd[63:32]), 64'(v));
      tick();
    end
    txr[1] = 1'b0;
    chk("drain_txv", 64'(txv[1]), 0);

    // get on empty RX ch0, then device push
    cyc = 1; stb = 1; wre = 0; adr = 0;
    for (int i = 0; i < 3; i++) begin tick(); chk("get_block", 64'(ack), 0); end
    rxd[31:0] = 32'h12345678; rxt[0] = 1'b0; rxv[0] = 1'b1;
    tick();
    rxv[0] = 1'b0;
    chk("get_push_edge", 64'(ack), 0);
    tick();
    chk("get_ack", 64'(ack), 1);
    chk("get_dat", 64'(dat_o), 64'h12345678);
    chk("get_tag", 64'(tag_o), 0);
    cyc = 0; stb = 0;
    tick();
    chk("dat_hold", 64'(dat_o), 64'h12345678);

    // fill RX ch1, then simultaneous push and get while full
    rxv[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rxd[63:32] = 32'hA0000000 + 32'(i); rxt[1] = i[0];
      tick();
    end
    rxv[1] = 1'b0;
    chk("rx_full", 64'(rxr[1]), 0);
    cyc = 1; stb = 1; wre = 0; adr = 1;
    rxd[63:32] = 32'hA0000004; rxt[1] = 1'b0; rxv[1] = 1'b1;
    tick();
    rxv[1] = 1'b0; cyc = 0; stb = 0;
    chk("both_ack", 64'(ack), 1);
    chk("both_dat", 64'(dat_o), 64'hA0000000);
    chk("both_rxr", 64'(rxr[1]), 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      xfer(1'b0, 1, 0, 0, n, rd, rt);
      chk("rx_order", 64'(rd), 64'(32'hA0000000 + 32'(i)));
      chk("rx_tag", 64'(rt), 64'((i == 4) ? 1'b0 : i[0]));
    end
    chk("rx_drained_rxr", 64'(rxr[1]), 1);
    tick();

    // reset while a put is blocked on a full TX ch0
    for (int i = 1; i <= 3; i++) xfer(1'b1, 0, 32'(i * 16'h11), 1'b0, n, rd, rt);
    cyc = 1; stb = 1; wre = 1; adr = 0; dat_i = 32'h55; tag_i = 0;
    tick(); tick();
    chk("blk_noack", 64'(ack), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 64'(ack), 0);
    chk("mid_rst_txv", 64'(txv), 0);
    chk("mid_rst_rxr", 64'(rxr), 2'b11);
    chk("mid_rst_dat", 64'(dat_o), 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ack && n < 20);
    cyc = 0; stb = 0;
    chk("post_rst_ack", 64'(n), 1);
    chk("post_rst_txd", 64'(txd[31:0]), 64'h55);
    chk("post_rst_txv", 64'(txv), 2'b01);
    tick();

`ifdef AEMB_XSL_TIMEOUT_EN
    xfer(1'b0, 0, 0, 0, n, rd, rt);
    chk("to_lat", 64'(n), 8);
    chk("to_dat", 64'(rd), 0);
    chk("to_err", 64'(err[0]), 1);
    tick(); tick(); tick();
    chk("to_sticky", 64'(err), 2'b01);
`else
    cyc = 1; stb = 1; wre = 0; adr = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("noto_block", 64'(ack), 0);
    cyc = 0; stb = 0;
    tick();
    chk("noto_err", 64'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
